// File: rtl/display_scan_controller_flickinger.sv
// Seven-segment scan sequencer: digit-refresh prescaler, four-slot digit select,
// operand/result source mode and per-slot leading-zero / positive-sign blanking.
module display_scan_controller_flickinger #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        entry_strobe,
  input  logic        compute_strobe,
  input  logic        clear_strobe,
  input  logic [3:0]  ab_msd,
  input  logic [11:0] alu_out,
  input  logic        input_sign,
  input  logic        alu_sign,
  output logic [1:0]  four_to_one_sel,
  output logic        two_to_one_sel,
  output logic        blank,
  output logic        digit_tick
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic {
    ENTRY  = 1'b0,
    RESULT = 1'b1
  } mode_t;

  logic [CNT_W-1:0] prescaler_q, prescaler_d;
  logic [1:0]       sel_q, sel_d;
  mode_t            mode_q, mode_d;
  logic             tick_q, tick_d;
  logic             term_cnt;

  always_comb begin
    term_cnt    = (prescaler_q == CNT_W'(REFRESH_DIV - 1));
    prescaler_d = term_cnt ? '0 : prescaler_q + CNT_W'(1);
    sel_d       = term_cnt ? sel_q + 2'd1 : sel_q;
    tick_d      = term_cnt;
    // Clear outranks entry, which outranks compute.
    mode_d = mode_q;
    if (clear_strobe || entry_strobe) begin
      mode_d = ENTRY;
    end else if (compute_strobe) begin
      mode_d = RESULT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler_q <= '0;
      sel_q       <= 2'd0;
      mode_q      <= ENTRY;
      tick_q      <= 1'b0;
    end else begin
      prescaler_q <= prescaler_d;
      sel_q       <= sel_d;
      mode_q      <= mode_d;
      tick_q      <= tick_d;
    end
  end

  // Operand entry never has a hundreds digit, so its MSD slot is always dark.
  always_comb begin
    blank = 1'b0;
    unique case (sel_q)
      2'd0: blank = (mode_q == RESULT) ? ~alu_sign : ~input_sign;
      2'd1: blank = (mode_q == RESULT) ? (alu_out[11:8] == 4'd0) : 1'b1;
      2'd2: blank = (mode_q == RESULT) ? ((alu_out[11:8] == 4'd0) && (alu_out[7:4] == 4'd0))
                                       : (ab_msd == 4'd0);
      2'd3: blank = 1'b0;
      default: blank = 1'b0;
    endcase
  end

  assign four_to_one_sel = sel_q;
  assign two_to_one_sel  = (mode_q == RESULT);
  assign digit_tick      = tick_q;

endmodule

// File: tb/tb_display_scan_controller_flickinger.sv
// Self-checking bench for the display scan controller: hand sequences, a blanking
// vector table and randomized strobes/data against a behavioural model.
module tb_display_scan_controller_flickinger;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        entry_strobe = 1'b0, compute_strobe = 1'b0, clear_strobe = 1'b0;
  logic [3:0]  ab_msd = 4'd0;
  logic [11:0] alu_out = 12'd0;
  logic        input_sign = 1'b0, alu_sign = 1'b0;
  logic [1:0]  four_to_one_sel;
  logic        two_to_one_sel, blank, digit_tick;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;       // rising edges since reset release
  bit m_res = 1'b0;  // model mode: 1 = showing ALU result

  display_scan_controller_flickinger #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .reset(reset),
    .entry_strobe(entry_strobe), .compute_strobe(compute_strobe), .clear_strobe(clear_strobe),
    .ab_msd(ab_msd), .alu_out(alu_out), .input_sign(input_sign), .alu_sign(alu_sign),
    .four_to_one_sel(four_to_one_sel), .two_to_one_sel(two_to_one_sel),
    .blank(blank), .digit_tick(digit_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          res;
    logic [3:0]  msd;
    logic [11:0] alu;
    bit          isg;
    bit          asg;
    logic [0:3]  exp;  // expected blank for slot 0..3
  } blank_vec_t;

  // Displayed digits for the three numeric slots; a slot goes dark while every
  // digit up to and including it is zero, except the last which always shows.
  function automatic logic model_blank(int slot, bit res, logic [3:0] msd, logic [11:0] alu,
                                       bit isg, bit asg);
    logic [3:0] d[3];
    if (slot == 0) return res ? !asg : !isg;
    if (slot == 3) return 1'b0;
    if (res) begin
      d[0] = alu[11:8]; d[1] = alu[7:4]; d[2] = alu[3:0];
    end else begin
      d[0] = 4'd0; d[1] = msd; d[2] = 4'd0;
    end
    for (int i = 0; i < slot; i++) if (d[i] != 4'd0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int model_sel();
    return (cyc / DIV) % 4;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all(input string nm);
    chk({nm, "_sel"}, 32'(four_to_one_sel), 32'(model_sel()));
    chk({nm, "_mode"}, 32'(two_to_one_sel), 32'(m_res));
    chk({nm, "_tick"}, 32'(digit_tick), 32'(cyc > 0 && cyc % DIV == 0));
    chk({nm, "_blank"}, 32'(blank),
        32'(model_blank(model_sel(), m_res, ab_msd, alu_out, input_sign, alu_sign)));
  endtask

  // Called at a falling edge; drives strobes for one rising edge, returns at the next falling edge.
  task automatic step(input bit e, input bit c, input bit cl);
    entry_strobe = e; compute_strobe = c; clear_strobe = cl;
    @(posedge clk);
    if (!reset) begin
      cyc++;
      if (cl || e) m_res = 1'b0;
      else if (c) m_res = 1'b1;
    end
    @(negedge clk);
    entry_strobe = 1'b0; compute_strobe = 1'b0; clear_strobe = 1'b0;
  endtask

  blank_vec_t vecs[7];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b1, 4'd0, 12'h007, 1'b0, 1'b0, 4'b1110};
    vecs[1] = '{1'b1, 4'd0, 12'h105, 1'b0, 1'b1, 4'b0000};
    vecs[2] = '{1'b1, 4'd0, 12'h040, 1'b0, 1'b0, 4'b1100};
    vecs[3] = '{1'b0, 4'd0, 12'h123, 1'b0, 1'b0, 4'b1110};
    vecs[4] = '{1'b0, 4'd3, 12'h000, 1'b1, 1'b0, 4'b0100};
    vecs[5] = '{1'b1, 4'd0, 12'h900, 1'b0, 1'b1, 4'b0000};
    vecs[6] = '{1'b0, 4'd0, 12'h999, 1'b1, 1'b1, 4'b0110};

    // Reset values, with a strobe applied during reset that must be ignored
    repeat (2) @(negedge clk);
    compute_strobe = 1'b1;
    @(negedge clk);
    compute_strobe = 1'b0;
    chk("rst_sel", 32'(four_to_one_sel), 32'd0);
    chk("rst_mode", 32'(two_to_one_sel), 32'd0);
    chk("rst_tick", 32'(digit_tick), 32'd0);
    chk("rst_blank", 32'(blank), 32'd1);
    reset = 1'b0; cyc = 0; m_res = 1'b0;

    // Scan: ticks after edges 4, 8, 12, 16; select walks 0,1,2,3,0
    for (int c = 1; c <= 17; c++) begin
      step(0, 0, 0);
      chk("scan_tick", 32'(digit_tick), 32'(c == 4 || c == 8 || c == 12 || c == 16));
      chk("scan_sel", 32'(four_to_one_sel), 32'((c / 4) % 4));
    end

    // Mode switching
    step(0, 1, 0); chk("compute_to_result", 32'(two_to_one_sel), 32'd1);
    step(1, 0, 0); chk("entry_to_entry", 32'(two_to_one_sel), 32'd0);
    step(0, 1, 0);
    step(0, 0, 1); chk("clear_from_result", 32'(two_to_one_sel), 32'd0);
    step(0, 1, 0);
    repeat (20) step(0, 0, 0);
    chk("hold_20", 32'(two_to_one_sel), 32'd1);
    step(1, 1, 0); chk("prio_entry_compute", 32'(two_to_one_sel), 32'd0);
    step(0, 1, 0);
    step(1, 1, 1); chk("prio_all_three", 32'(two_to_one_sel), 32'd0);
    check_all("mode_seq");

    // Mode change landing on a tick edge
    for (int i = 0; i < DIV && (cyc % DIV) != DIV - 1; i++) step(0, 0, 0);
    begin
      int sel_before;
      sel_before = model_sel();
      step(0, 1, 0);
      chk("tick_mode_change_tick", 32'(digit_tick), 32'd1);
      chk("tick_mode_change_sel", 32'(four_to_one_sel), 32'((sel_before + 1) % 4));
      chk("tick_mode_change_mode", 32'(two_to_one_sel), 32'd1);
    end

    // Blanking table: every slot of each vector
    foreach (vecs[v]) begin
      if (vecs[v].res) step(0, 1, 0); else step(1, 0, 0);
      ab_msd = vecs[v].msd; alu_out = vecs[v].alu;
      input_sign = vecs[v].isg; alu_sign = vecs[v].asg;
      #1;
      for (int k = 0; k < 4 * DIV; k++) begin
        chk($sformatf("blank_vec%0d_slot%0d", v, model_sel()), 32'(blank),
            32'(vecs[v].exp[model_sel()]));
        step(0, 0, 0);
      end
    end

    // Asynchronous reset mid-scan in RESULT at slot 2
    step(0, 1, 0);
    for (int i = 0; i < 4 * DIV && model_sel() != 2; i++) step(0, 0, 0);
    chk("pre_reset_sel", 32'(four_to_one_sel), 32'd2);
    chk("pre_reset_mode", 32'(two_to_one_sel), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_sel", 32'(four_to_one_sel), 32'd0);
    chk("async_rst_mode", 32'(two_to_one_sel), 32'd0);
    chk("async_rst_tick", 32'(digit_tick), 32'd0);
    @(negedge clk);
    step(0, 1, 0);
    chk("strobe_in_reset", 32'(two_to_one_sel), 32'd0);
    reset = 1'b0; cyc = 0; m_res = 1'b0;
    for (int c = 1; c <= DIV; c++) begin
      step(0, 0, 0);
      chk("post_reset_tick", 32'(digit_tick), 32'(c == DIV));
    end

    // Randomized strobes and data against the model
    for (int n = 0; n < 400; n++) begin
      ab_msd     = 4'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 15));
      alu_out    = 12'($urandom);
      if ($urandom_range(0, 2) == 0) alu_out[11:8] = 4'd0;
      if ($urandom_range(0, 2) == 0) alu_out[7:4] = 4'd0;
      input_sign = 1'($urandom);
      alu_sign   = 1'($urandom);
      step($urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 11) == 0);
      check_all("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
